// File: rtl/dmem_if.sv
// ---------------------------------------------------------------------------
// dmem_if
// Core data-bus bundle between the load/store unit (master) and a data
// memory responder (slave). Request phase uses req/gnt; each accepted
// request is answered by exactly one rvalid beat, in order.
//
// Signals
//   data_req    master->slave  request valid, fields held stable until gnt
//   data_addr   master->slave  32-bit byte address
//   data_we     master->slave  1 = write, 0 = read
//   data_be     master->slave  byte enables, bit n covers bits [8n+7:8n]
//   data_wdata  master->slave  lane-aligned write data
//   data_gnt    slave->master  request accepted this cycle
//   data_rvalid slave->master  response beat valid
//   data_rdata  slave->master  full read word (0 for writes/errors)
//   data_err    slave->master  response carries an access error
// ---------------------------------------------------------------------------
interface dmem_if;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Slave end of the core req/gnt/rvalid data bus. Word-organised RAM with
// byte-enable writes, a fixed read latency, a bounded number of outstanding
// requests and an out-of-range error response.
//
// Parameters
//   MEM_DEPTH_WORDS  number of 32-bit words
//   BASE_ADDR        byte address of word 0 (4-byte aligned)
//   RD_LATENCY       cycles from accept edge to rvalid, 1..4
//   MAX_OUTSTANDING  accepted-but-unanswered limit, 1..RD_LATENCY
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous reset, active-low
//   gnt_stall_i  external stall, forces grant low
//   bus          dmem_if slave modport (req/addr/we/be/wdata in,
//                gnt/rvalid/rdata/err out)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int          MEM_DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          RD_LATENCY      = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   gnt_stall_i,
    dmem_if.slave  bus
);

    localparam int          IDX_W     = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam int          CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [29:0] DEPTH_W30 = 30'(MEM_DEPTH_WORDS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]                 r_mem [MEM_DEPTH_WORDS];
    logic [CNT_W-1:0]            r_cnt;
    logic [RD_LATENCY-1:0]       r_vld_p;
    logic [RD_LATENCY-1:0][31:0] r_rdata_p;
    logic [RD_LATENCY-1:0]       r_err_p;

    logic [31:0]      w_off;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_gnt;
    logic             w_accept;
    logic             w_issue;
    logic [31:0]      w_rd_word;
    logic             w_unused_off;

    // Address decode: the subtraction wraps for addresses below BASE_ADDR,
    // so the explicit lower-bound compare is what rejects them.
    assign w_off        = bus.data_addr - BASE_ADDR;
    assign w_in_range   = (bus.data_addr >= BASE_ADDR) && (w_off[31:2] < DEPTH_W30);
    assign w_idx        = w_off[IDX_W+1:2];
    assign w_unused_off = ^w_off[1:0];

    // Grant looks only at the registered count: a response leaving on this
    // edge does not open a slot for the request competing on the same edge.
    assign w_gnt    = rst_ni & bus.data_req & ~gnt_stall_i & (r_cnt < MAX_CNT);
    assign w_accept = bus.data_req & w_gnt;

    assign w_rd_word = (w_in_range && !bus.data_we) ? r_mem[w_idx] : 32'h0;

    // A request counts as answered on the edge that raises rvalid for it,
    // i.e. when its token moves into the last pipe stage. With a single
    // stage that is the accept edge itself.
    generate
        if (RD_LATENCY == 1) begin : g_issue_l1
            assign w_issue = w_accept;
        end else begin : g_issue_ln
            assign w_issue = r_vld_p[RD_LATENCY-2];
        end
    endgenerate

    // RAM write port: lanes update on the accept edge; out-of-range writes
    // are dropped so they never alias onto a real word.
    always_ff @(posedge clk_i) begin
        if (w_accept && bus.data_we && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures the response at the accept edge; idle slots carry
    // zero data so the outputs are zero whenever rvalid is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p   <= '0;
            r_rdata_p <= '0;
            r_err_p   <= '0;
            r_cnt     <= '0;
        end else begin
            r_vld_p[0]   <= w_accept;
            r_rdata_p[0] <= w_accept ? w_rd_word : 32'h0;
            r_err_p[0]   <= w_accept & ~w_in_range;
            // Stages 1..RD_LATENCY-1: plain shift toward the output
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_vld_p[s]   <= r_vld_p[s-1];
                r_rdata_p[s] <= r_rdata_p[s-1];
                r_err_p[s]   <= r_err_p[s-1];
            end
            if (w_accept && !w_issue) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_accept && w_issue) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.data_gnt    = w_gnt;
    assign bus.data_rvalid = r_vld_p[RD_LATENCY-1];
    assign bus.data_rdata  = r_rdata_p[RD_LATENCY-1];
    assign bus.data_err    = r_err_p[RD_LATENCY-1];

endmodule
